// File: rtl/hack_ctrl_pkg.sv
// Shared types and constants for the Hack CPU control path: sequencer states,
// C-instruction/jump bit positions and the jump-field encodings.
package hack_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_EXEC,
    S_UPDATE,
    S_FAULT,
    S_HALT
  } state_t;

  localparam int C_BIT  = 15;
  localparam int J2_BIT = 2;   // jump if out < 0
  localparam int J1_BIT = 1;   // jump if out == 0
  localparam int J0_BIT = 0;   // jump if out > 0

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// Jump condition for a Hack instruction given the ALU zr/ng flags.
// Purely combinational; A-instructions never jump.
module jump_cond
  import hack_ctrl_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               zr,
  input  logic               ng,
  output logic               jump
);

  logic pos;
  assign pos  = ~zr & ~ng;
  assign jump = instr[C_BIT] &
                ((instr[J2_BIT] & ng) | (instr[J1_BIT] & zr) | (instr[J0_BIT] & pos));

  // comp/dest fields are the datapath's business
  wire unused_fields = ^instr[C_BIT-1:J2_BIT+1];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving the Hack PC reset/load/inc strobes.
// Optional self-jump halt detection is enabled with HALT_DETECT_EN.
module pc_sequencer
  import hack_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int INSTR_W     = 16,
  parameter int ROM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               zr,
  input  logic               ng,
  output logic               pc_reset,
  output logic               pc_load,
  output logic               pc_inc,
  input  logic [ADDR_W-1:0]  pc_value,
  input  logic [ADDR_W-1:0]  a_value,
  output logic               fault,
  output logic               halted
);

  localparam int TW = (ROM_TIMEOUT > 1) ? $clog2(ROM_TIMEOUT) : 1;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          exec_first;
  logic          jump, jump_r;

  jump_cond #(.INSTR_W(INSTR_W)) u_jump (
    .instr (instr),
    .zr    (zr),
    .ng    (ng),
    .jump  (jump)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      instr      <= '0;
      tcnt       <= '0;
      exec_first <= 1'b0;
      jump_r     <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          tcnt  <= '0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (rom_ack) begin
            instr      <= rom_data;
            exec_first <= 1'b1;
            state      <= S_EXEC;
          end else if (tcnt == TW'(ROM_TIMEOUT - 1)) begin
            state <= S_FAULT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_EXEC: begin
          exec_first <= 1'b0;
          // flags are only meaningful in the exec_done cycle
          if (exec_done) begin
            jump_r <= jump;
            state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          tcnt <= '0;
`ifdef HALT_DETECT_EN
          if (jump_r && (a_value == pc_value)) state <= S_HALT;
          else                                 state <= S_FETCH;
`else
          state <= S_FETCH;
`endif
        end
        S_FAULT: state <= S_FAULT;
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  assign pc_reset    = (state == S_INIT);
  assign rom_req     = (state == S_FETCH);
  assign instr_valid = (state == S_EXEC) && exec_first;
  assign pc_load     = (state == S_UPDATE) && jump_r;
  assign pc_inc      = (state == S_UPDATE) && !jump_r;
  assign fault       = (state == S_FAULT);

`ifdef HALT_DETECT_EN
  assign halted = (state == S_HALT);
`else
  assign halted = 1'b0;
  wire unused_pc = ^{pc_value, a_value};
`endif

endmodule
